// File: rtl/matmul_pkg.sv
// Types and default widths shared by the matmul memory controller and the result unloader.
package matmul_pkg;

  localparam int unsigned MATMUL_ADDR_W = 12;
  localparam int unsigned MATMUL_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StFin
  } unload_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs read data while the stream sink stalls.
module skid_fifo2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Head is read straight from storage, so it stays put until popped.
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == 2'd2)));
  no_underflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count_q == 2'd0)));

endmodule

// File: rtl/result_unloader.sv
// Drains the matmul output memory through its read port and streams the words out.
module result_unloader
  import matmul_pkg::*;
#(
  parameter int unsigned ADDR_W = MATMUL_ADDR_W,
  parameter int unsigned DATA_W = MATMUL_DATA_W,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  // Wide enough to hold DEPTH = 2**ADDR_W without aliasing a wrapped address.
  localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

  unload_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              issue;
  logic              drained;
  logic [2:0]        occupancy;

  assign m_valid   = (fifo_count != 2'd0);
  assign pop       = m_valid & m_ready;
  // Slots committed after this edge: buffered + returning - leaving.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == StRead) && (occupancy < 3'd2);
  assign drained   = !inflight_q &&
                     ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_cnt_q == LastIdx);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRead;
            busy_q   <= 1'b1;
            addr_q   <= '0;
            rd_cnt_q <= '0;
          end
        end
        StRead: begin
          if (issue) begin
            addr_q   <= addr_q + 1'b1;
            rd_cnt_q <= rd_cnt_q + 1'b1;
            if (rd_cnt_q == LastIdx) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (drained) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  skid_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (inflight_q),
    .wdata({inflight_last_q, rd_data}),
    .pop  (pop),
    .rdata(fifo_head),
    .count(fifo_count)
  );

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign m_data  = fifo_head[DATA_W-1:0];
  assign m_last  = fifo_head[DATA_W];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
